dispatch_sched_ctrl: RTL and testbench
======================================

# dispatch_sched_ctrl

Dispatch scheduler for the two-slot in-order dispatch stage. It sits directly after the slot-rotation logic that presents the two oldest decoded instructions as slot 0 (older) and slot 1 (younger). It decides each cycle which slots may leave, based on:

- destination issue-queue space,
- ROB free entries,
- a serialization state machine for CSR/fence-class instructions.

It produces the per-slot ready handshake, one-hot enqueue strobes and the ROB allocation count.

## Interface
Parameters:
- DEST_NUM, 4, number of destination issue queues; `disp_dest` index width DW = $clog2(DEST_NUM)
- ROBF_W, 6, width of the ROB free-entry count

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- flush_i  in  1  pipeline flush, synchronous
- slot0_valid_i / slot1_valid_i  in  1  slot holds an instruction
- slot0_dest_i / slot1_dest_i  in  DW  destination queue index (`disp_dest`)
- slot0_serial_i / slot1_serial_i  in  1  instruction is serializing (CSR, fence, fence.i)
- slot0_ready_o / slot1_ready_o  out  1  slot is accepted this cycle; fire = valid & ready
- dest_ready1_i  in  DEST_NUM  queue d has ≥1 free entry
- dest_ready2_i  in  DEST_NUM  queue d has ≥2 free entries; implies dest_ready1_i[d]
- enq0_o / enq1_o  out  DEST_NUM  one-hot enqueue strobe for slot 0 / slot 1
- rob_free_i  in  ROBF_W  ROB free entries
- rob_empty_i  in  1  ROB holds no instructions
- rob_alloc_o  out  2  ROB entries allocated this cycle (0..2)
- serial_commit_i  in  1  the outstanding serializing instruction has committed
- busy_o  out  1  state ≠ NORM
- stall_cnt_o  out  32  count of cycles with slot0 valid and no fire

## Operation
States:
- NORM: normal dispatch.
- DRAIN: a serializing instruction in slot 0 waits for the ROB to empty.
- WAITC: the serializing instruction has dispatched; waiting for its commit.

Transitions:
- NORM → DRAIN when slot0_valid_i & slot0_serial_i & ~flush_i.
- DRAIN → WAITC when slot 0 fires.
- WAITC → NORM when serial_commit_i.
- flush_i moves any state to NORM. flush_i takes priority over every other transition.

Fire rules (all combinational):
- NORM, slot 0 fires iff all hold:
  - slot0_valid_i
  - ~slot0_serial_i
  - dest_ready1_i[slot0_dest_i]
  - rob_free_i ≥ 1
  - ~flush_i
- NORM, slot 1 fires iff all hold:
  - slot 0 fires
  - slot1_valid_i
  - ~slot1_serial_i
  - rob_free_i ≥ 2
  - queue space: dest_ready2_i[d] if slot1_dest_i == slot0_dest_i, else dest_ready1_i[slot1_dest_i]
- A serializing instruction in slot 1 never fires alongside slot 0. It waits until it rotates into slot 0.
- DRAIN: slot 0 fires iff slot0_valid_i & rob_empty_i & dest_ready1_i[slot0_dest_i] & ~flush_i. Slot 1 never fires.
- WAITC: no slot fires.
- Ready without valid: slotN_ready_o may be high only when slotN_valid_i is high. Slot 1 is never ready unless slot 0 fires in the same cycle.
- enq0_o = fire0 ? onehot(slot0_dest_i) : 0, and likewise enq1_o from fire1.
- rob_alloc_o = fire0 + fire1.
- stall_cnt_o increments when slot0_valid_i & ~fire0 & ~flush_i; it wraps at 2^32. It is not cleared by flush_i.
- busy_o is high in DRAIN and WAITC.

## Timing
- Reset values: state NORM, stall_cnt_o 0, busy_o 0. With all inputs at 0 after reset, every ready, enq and rob_alloc output is 0.
- Handshake outputs are zero-latency combinational from inputs and state. State and counter update on the rising clk_i edge.
- flush_i cycle: no fire, no enq, rob_alloc_o 0. State is NORM on the next cycle.
- A serializing instruction arriving with rob_empty_i already 1:
  - cycle 0: NORM → DRAIN
  - cycle 1: fires
  - earliest new dispatch: the cycle after serial_commit_i
- serial_commit_i in NORM or DRAIN is ignored.
- arst_i asserted mid-operation returns immediately to reset values, regardless of clk_i.
- rob_free_i == 0 blocks both slots. rob_free_i == 1 allows at most slot 0.

## Test plan
- Dual dispatch, different queues: slot0 dest 0, slot1 dest 2, rob_free 10, all ready → both ready, enq0=0001, enq1=0100, rob_alloc 2, stall_cnt unchanged.
- Same-queue contention: both dest 1, dest_ready1[1]=1, dest_ready2[1]=0 → slot0 fires (enq0=0010), slot1 ready 0, rob_alloc 1. Raise dest_ready2[1] → both fire.
- ROB limit: rob_free 1, both valid → only slot0 fires. rob_free 0 → none fire, stall_cnt increments 1 per cycle.
- Serialization: slot0 serial, rob_empty 0 for 3 cycles → busy 1, no fire, stall_cnt +4 including the entry cycle. rob_empty 1 → slot0 fires alone. Subsequent normal instructions are blocked until serial_commit_i pulses, then dispatch resumes the next cycle.
- Serial in slot 1: slot0 normal, slot1 serial → only slot0 fires, state stays NORM.
- Flush in WAITC and DRAIN → outputs 0 that cycle, state NORM and busy 0 next cycle. arst_i mid-DRAIN → busy 0 and stall_cnt 0 immediately.

Source files
------------

// File: rtl/dispatch_sched_ctrl.sv
// rtl/dispatch_sched_ctrl.sv - two-slot in-order dispatch scheduler with serialization FSM
//
// Purpose: decides each cycle which of the two oldest decoded instructions
// (slot 0 older, slot 1 younger) leave dispatch, based on issue-queue space,
// ROB free entries and a NORM/DRAIN/WAITC serialization state machine.
//
// Ports:
//   clk_i, arst_i            clock, asynchronous active-high reset
//   flush_i                  synchronous pipeline flush (blocks all fires)
//   slotN_valid/dest/serial  slot N instruction, destination queue, serializing flag
//   slotN_ready_o            slot N accepted this cycle
//   dest_ready1_i/2_i        per-queue >=1 / >=2 free entries
//   enq0_o, enq1_o           one-hot enqueue strobes for slot 0 / slot 1
//   rob_free_i, rob_empty_i  ROB free count / ROB empty
//   rob_alloc_o              ROB entries allocated this cycle (0..2)
//   serial_commit_i          outstanding serializing instruction committed
//   busy_o                   serialization in progress (DRAIN or WAITC)
//   stall_cnt_o              cycles with slot 0 valid but not firing
module dispatch_sched_ctrl #(
  parameter int DEST_NUM = 4,
  parameter int ROBF_W   = 6,
  localparam int DW      = (DEST_NUM > 1) ? $clog2(DEST_NUM) : 1
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                flush_i,
  input  logic                slot0_valid_i,
  input  logic                slot1_valid_i,
  input  logic [DW-1:0]       slot0_dest_i,
  input  logic [DW-1:0]       slot1_dest_i,
  input  logic                slot0_serial_i,
  input  logic                slot1_serial_i,
  output logic                slot0_ready_o,
  output logic                slot1_ready_o,
  input  logic [DEST_NUM-1:0] dest_ready1_i,
  input  logic [DEST_NUM-1:0] dest_ready2_i,
  output logic [DEST_NUM-1:0] enq0_o,
  output logic [DEST_NUM-1:0] enq1_o,
  input  logic [ROBF_W-1:0]   rob_free_i,
  input  logic                rob_empty_i,
  output logic [1:0]          rob_alloc_o,
  input  logic                serial_commit_i,
  output logic                busy_o,
  output logic [31:0]         stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_NORM  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WAITC = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   fire0, fire1;
  logic   q0_space, q1_space;
  logic   rob_ge1, rob_ge2;

  assign rob_ge1 = (rob_free_i != '0);
  assign rob_ge2 = (rob_free_i > ROBF_W'(1));

  // Slot 1 targeting the same queue as slot 0 needs two free entries there.
  assign q0_space = dest_ready1_i[slot0_dest_i];
  assign q1_space = (slot1_dest_i == slot0_dest_i) ? dest_ready2_i[slot1_dest_i]
                                                   : dest_ready1_i[slot1_dest_i];

  always_comb begin
    fire0   = 1'b0;
    fire1   = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_NORM: begin
        fire0 = slot0_valid_i & ~slot0_serial_i & q0_space & rob_ge1 & ~flush_i;
        // A serializing slot-1 instruction waits until it rotates into slot 0.
        fire1 = fire0 & slot1_valid_i & ~slot1_serial_i & rob_ge2 & q1_space;
        if (slot0_valid_i & slot0_serial_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        fire0 = slot0_valid_i & rob_empty_i & q0_space & ~flush_i;
        if (fire0) state_d = ST_WAITC;
      end
      ST_WAITC: begin
        if (serial_commit_i) state_d = ST_NORM;
      end
      default: state_d = ST_NORM;
    endcase
    if (flush_i) state_d = ST_NORM;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_NORM;
    end else begin
      state_q <= state_d;
    end
  end

  // Not cleared by flush: this is a performance counter, not pipeline state.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      stall_cnt_o <= '0;
    end else if (slot0_valid_i & ~fire0 & ~flush_i) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

  assign slot0_ready_o = fire0;
  assign slot1_ready_o = fire1;
  assign enq0_o        = fire0 ? (DEST_NUM'(1) << slot0_dest_i) : '0;
  assign enq1_o        = fire1 ? (DEST_NUM'(1) << slot1_dest_i) : '0;
  assign rob_alloc_o   = {1'b0, fire0} + {1'b0, fire1};
  assign busy_o        = (state_q != ST_NORM);

endmodule

// File: tb/tb_dispatch_sched_ctrl.sv
// tb/tb_dispatch_sched_ctrl.sv - scoreboard bench for dispatch_sched_ctrl
module tb_dispatch_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic [1:0]  d0 = '0, d1 = '0;
  logic        r0, r1;
  logic [3:0]  rdy1 = '0, rdy2 = '0;
  logic [3:0]  e0, e1;
  logic [5:0]  free = '0;
  logic        empty = 1'b0, commit = 1'b0;
  logic [1:0]  alloc;
  logic        busy;
  logic [31:0] stall;

  typedef struct {
    logic        r0, r1;
    logic [3:0]  e0, e1;
    logic [1:0]  al;
    logic        busy;
    logic [31:0] stall;
    int          id;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   vec_id = 0;

  dispatch_sched_ctrl #(.DEST_NUM(4), .ROBF_W(6)) dut (
    .clk_i(clk), .arst_i(rst), .flush_i(flush),
    .slot0_valid_i(v0), .slot1_valid_i(v1),
    .slot0_dest_i(d0), .slot1_dest_i(d1),
    .slot0_serial_i(s0), .slot1_serial_i(s1),
    .slot0_ready_o(r0), .slot1_ready_o(r1),
    .dest_ready1_i(rdy1), .dest_ready2_i(rdy2),
    .enq0_o(e0), .enq1_o(e1),
    .rob_free_i(free), .rob_empty_i(empty),
    .rob_alloc_o(alloc), .serial_commit_i(commit),
    .busy_o(busy), .stall_cnt_o(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL v%0d %s got %0h want %0h", id, name, act, want);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("slot0_ready", e.id, {31'd0, r0}, {31'd0, e.r0});
      chk("slot1_ready", e.id, {31'd0, r1}, {31'd0, e.r1});
      chk("enq0", e.id, {28'd0, e0}, {28'd0, e.e0});
      chk("enq1", e.id, {28'd0, e1}, {28'd0, e.e1});
      chk("rob_alloc", e.id, {30'd0, alloc}, {30'd0, e.al});
      chk("busy", e.id, {31'd0, busy}, {31'd0, e.busy});
      chk("stall_cnt", e.id, stall, e.stall);
    end
  end

  task automatic drv(input logic iv0, input logic is0, input logic [1:0] id0,
                     input logic iv1, input logic is1, input logic [1:0] id1,
                     input logic [5:0] ifree, input logic iempty,
                     input logic icommit, input logic iflush);
    v0 = iv0; s0 = is0; d0 = id0;
    v1 = iv1; s1 = is1; d1 = id1;
    free = ifree; empty = iempty; commit = icommit; flush = iflush;
  endtask

  // Push expectation for the current input vector, then advance one cycle.
  task automatic expect_step(input logic er0, input logic er1, input logic [3:0] ee0,
                             input logic [3:0] ee1, input logic [1:0] eal,
                             input logic ebusy, input logic [31:0] estall);
    exp_t e;
    e.r0 = er0; e.r1 = er1; e.e0 = ee0; e.e1 = ee1;
    e.al = eal; e.busy = ebusy; e.stall = estall; e.id = vec_id;
    vec_id++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // v0 reset state, all inputs low
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);

    // v1 dual dispatch, different queues
    rdy1 = 4'b1111; rdy2 = 4'b1111;
    drv(1, 0, 2'd0, 1, 0, 2'd2, 6'd10, 0, 0, 0);
    expect_step(1, 1, 4'b0001, 4'b0100, 2'd2, 0, 0);

    // v2 same queue, only one entry free
    rdy1 = 4'b0010; rdy2 = 4'b0000;
    drv(1, 0, 2'd1, 1, 0, 2'd1, 6'd10, 0, 0, 0);
    expect_step(1, 0, 4'b0010, 4'b0000, 2'd1, 0, 0);
    // v3 two entries free
    rdy2 = 4'b0010;
    expect_step(1, 1, 4'b0010, 4'b0010, 2'd2, 0, 0);

    // v4 rob_free 1 allows only slot 0
    rdy1 = 4'b1111; rdy2 = 4'b1111;
    drv(1, 0, 2'd0, 1, 0, 2'd2, 6'd1, 0, 0, 0);
    expect_step(1, 0, 4'b0001, 4'b0000, 2'd1, 0, 0);
    // v5-v7 rob_free 0 blocks everything; stall counts up
    free = 6'd0;
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 1);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 2);

    // v8 serializing instruction in slot 1 does not ride along
    drv(1, 0, 2'd0, 1, 1, 2'd2, 6'd10, 0, 0, 0);
    expect_step(1, 0, 4'b0001, 4'b0000, 2'd1, 0, 3);
    // v9 state stayed NORM
    drv(0, 0, 2'd0, 0, 0, 2'd0, 6'd10, 0, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 3);

    // v10 serial in slot 0, ROB not empty: entry cycle
    drv(1, 1, 2'd3, 1, 0, 2'd0, 6'd10, 0, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 3);
    // v11-v13 DRAIN waiting for ROB empty
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 4);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 5);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 6);
    // v14 ROB empty: slot 0 fires alone
    empty = 1'b1;
    expect_step(1, 0, 4'b1000, 4'b0000, 2'd1, 1, 7);
    // v15 WAITC blocks normal instructions
    drv(1, 0, 2'd0, 1, 0, 2'd2, 6'd10, 1, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 7);
    // v16 commit pulse, still blocked this cycle
    commit = 1'b1;
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 8);
    // v17 dispatch resumes
    commit = 1'b0;
    expect_step(1, 1, 4'b0001, 4'b0100, 2'd2, 0, 9);

    // v18-v19 serial with ROB empty: enter DRAIN, fire next cycle
    drv(1, 1, 2'd1, 0, 0, 2'd0, 6'd10, 1, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 9);
    expect_step(1, 0, 4'b0010, 4'b0000, 2'd1, 1, 10);
    // v20 flush in WAITC
    drv(1, 0, 2'd0, 1, 0, 2'd2, 6'd10, 1, 0, 1);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 10);
    // v21 back in NORM, counter kept across flush
    flush = 1'b0;
    expect_step(1, 1, 4'b0001, 4'b0100, 2'd2, 0, 10);

    // v22 enter DRAIN
    drv(1, 1, 2'd2, 0, 0, 2'd0, 6'd10, 0, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 10);
    // v23 flush in DRAIN while it could otherwise fire
    drv(1, 1, 2'd2, 0, 0, 2'd0, 6'd10, 1, 0, 1);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 11);
    // v24 NORM after flush
    drv(0, 0, 2'd0, 0, 0, 2'd0, 6'd10, 0, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 11);

    // v25-v26 into DRAIN again
    drv(1, 1, 2'd2, 0, 0, 2'd0, 6'd10, 0, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 11);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 1, 12);
    // v27 asynchronous reset between edges
    rst = 1'b1;
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // v28 out of reset
    rst = 1'b0;
    drv(0, 0, 2'd0, 0, 0, 2'd0, 6'd0, 0, 0, 0);
    expect_step(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);

    begin
      int guard = 0;
      while (q.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      if (q.size() > 0) begin
        total_cnt++;
        $display("FAIL drain_timeout got %0d pending want 0", q.size());
      end
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
